// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and sequencing controller for the 5-stage RISC-V core.
//
// Drives the stall/flush enables of the F/D/E/M/W pipeline registers and the
// execute-stage forwarding selects. It keeps a shadow scoreboard (rd, write
// enable, load flag) for the E, M and W stages. A small FSM sequences
// multi-cycle data-memory accesses.
//
// Data memory handshake: dmem_reqM says the M-stage access is in flight, and
// dmem_readyM says the memory completes it in the current cycle. Every cycle
// with the request up and ready low is a wait cycle. Once waiting starts, the
// wait lasts until ready is seen, and the ready cycle itself advances the
// pipeline.
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   rs1D, rs2D, rdD        decode-stage register indices
//   reg_writeD             decode-stage register write enable
//   result_srcD            decode result select, 2'b01 marks a load
//   pc_srcE                redirect resolved in E
//   dmem_reqM, dmem_readyM data memory request / completion
//   stallF..flushW         pipeline register stall/flush enables
//   forwardAE, forwardBE   operand selects: 00 regfile, 10 from M, 01 from W
//   bubble_cnt             saturating count of inserted bubbles
module hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] rs1D,
  input  logic [REG_W-1:0] rs2D,
  input  logic [REG_W-1:0] rdD,
  input  logic             reg_writeD,
  input  logic [1:0]       result_srcD,
  input  logic             pc_srcE,
  input  logic             dmem_reqM,
  input  logic             dmem_readyM,
  output logic             stallF,
  output logic             stallD,
  output logic             flushD,
  output logic             stallE,
  output logic             flushE,
  output logic             stallM,
  output logic             flushW,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic [1:0] {BOOT, RUN, MEM_WAIT} state_t;

  state_t state, stateNext;

  // Shadow scoreboard
  logic [REG_W-1:0] rdE, rdM, rdW;
  logic             weE, weM, weW;
  logic             ldE, ldM, ldW;
  logic [REG_W-1:0] rs1E, rs2E;

  logic       memWait;
  logic       loadUse;
  logic [1:0] bubbleInc;
  logic [CNT_W:0] cntSum;

  assign loadUse = ldE && weE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    stallF    = 1'b0;
    stallD    = 1'b0;
    flushD    = 1'b0;
    stallE    = 1'b0;
    flushE    = 1'b0;
    stallM    = 1'b0;
    flushW    = 1'b0;
    memWait   = 1'b0;
    bubbleInc = 2'd0;
    case (state)
      BOOT: begin
        flushD    = 1'b1;
        flushE    = 1'b1;
        stateNext = RUN;
      end
      RUN, MEM_WAIT: begin
        // The first RUN cycle that sees the request without ready already
        // freezes the pipeline. Redirect and load-use are only looked at
        // when nothing is waiting, because E is frozen during a wait.
        if ((state == MEM_WAIT || dmem_reqM) && !dmem_readyM) begin
          memWait   = 1'b1;
          stallF    = 1'b1;
          stallD    = 1'b1;
          stallE    = 1'b1;
          stallM    = 1'b1;
          flushW    = 1'b1;
          bubbleInc = 2'd1;
          stateNext = MEM_WAIT;
        end else begin
          stateNext = RUN;
          if (pc_srcE) begin
            flushD    = 1'b1;
            flushE    = 1'b1;
            bubbleInc = 2'd2;
          end else if (loadUse) begin
            stallF    = 1'b1;
            stallD    = 1'b1;
            flushE    = 1'b1;
            bubbleInc = 2'd1;
          end
        end
      end
      default: stateNext = BOOT;
    endcase
  end

  // Scoreboard advance. A memory wait freezes E and M and injects a bubble into W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdE <= '0; weE <= 1'b0; ldE <= 1'b0;
      rdM <= '0; weM <= 1'b0; ldM <= 1'b0;
      rdW <= '0; weW <= 1'b0; ldW <= 1'b0;
      rs1E <= '0;
      rs2E <= '0;
    end else if (memWait) begin
      rdW <= '0; weW <= 1'b0; ldW <= 1'b0;
    end else begin
      rdW <= rdM; weW <= weM; ldW <= ldM;
      rdM <= rdE; weM <= weE; ldM <= ldE;
      rs1E <= rs1D;
      rs2E <= rs2D;
      if (flushE) begin
        rdE <= '0; weE <= 1'b0; ldE <= 1'b0;
      end else begin
        rdE <= rdD;
        weE <= reg_writeD;
        ldE <= (result_srcD == 2'b01);
      end
    end
  end

  // Forwarding: the newer value in M wins over W. x0 is never forwarded.
  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (weM && (rdM != '0) && (rdM == rs1E))      forwardAE = 2'b10;
    else if (weW && (rdW != '0) && (rdW == rs1E)) forwardAE = 2'b01;
    if (weM && (rdM != '0) && (rdM == rs2E))      forwardBE = 2'b10;
    else if (weW && (rdW != '0) && (rdW == rs2E)) forwardBE = 2'b01;
  end

  // Saturating bubble counter. The extra sum bit catches overflow, including
  // a +2 step that would cross all-ones.
  assign cntSum = {1'b0, bubble_cnt} + {{(CNT_W-1){1'b0}}, bubbleInc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           bubble_cnt <= '0;
    else if (cntSum[CNT_W]) bubble_cnt <= '1;
    else                  bubble_cnt <= cntSum[CNT_W-1:0];
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam logic [6:0] IDLE_C = 7'b0000000;
  localparam logic [6:0] BOOT_C = 7'b0010100; // flushD, flushE
  localparam logic [6:0] RED_C  = 7'b0010100; // redirect: flushD, flushE
  localparam logic [6:0] LU_C   = 7'b1100100; // stallF, stallD, flushE
  localparam logic [6:0] WAIT_C = 7'b1101011; // stallF/D/E/M, flushW

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1D, rs2D, rdD;
  logic        reg_writeD;
  logic [1:0]  result_srcD;
  logic        pc_srcE;
  logic        dmem_reqM, dmem_readyM;
  logic        stallF, stallD, flushD, stallE, flushE, stallM, flushW;
  logic [1:0]  forwardAE, forwardBE;
  logic [15:0] bubble_cnt;
  logic [6:0]  ctrl;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_ctrl #(.REG_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD),
    .reg_writeD(reg_writeD), .result_srcD(result_srcD),
    .pc_srcE(pc_srcE), .dmem_reqM(dmem_reqM), .dmem_readyM(dmem_readyM),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .stallE(stallE),
    .flushE(flushE), .stallM(stallM), .flushW(flushW),
    .forwardAE(forwardAE), .forwardBE(forwardBE), .bubble_cnt(bubble_cnt)
  );

  assign ctrl = {stallF, stallD, flushD, stallE, flushE, stallM, flushW};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic we, input logic [1:0] rsrc);
    rs1D = rs1; rs2D = rs2; rdD = rd; reg_writeD = we; result_srcD = rsrc;
  endtask

  task automatic nop();
    set_d(5'd0, 5'd0, 5'd0, 1'b0, 2'b00);
  endtask

  initial begin
    rst_n = 1'b0; pc_srcE = 1'b0; dmem_reqM = 1'b0; dmem_readyM = 1'b0;
    nop();

    // reset state
    @(negedge clk);
    check_val("reset_ctrl", ctrl, BOOT_C);
    check_val("reset_cnt", bubble_cnt, 0);
    check_val("reset_fwdA", forwardAE, 2'b00);
    tick(); rst_n = 1'b1;
    @(negedge clk); check_val("boot_ctrl", ctrl, BOOT_C);
    tick();
    @(negedge clk); check_val("run_idle", ctrl, IDLE_C);
    check_val("run_cnt", bubble_cnt, 0);

    // load-use: lw x5 ; add x6,x5,x7
    tick(); set_d(5'd1, 5'd0, 5'd5, 1'b1, 2'b01);
    @(negedge clk); check_val("lw_issue", ctrl, IDLE_C);
    tick(); set_d(5'd5, 5'd7, 5'd6, 1'b1, 2'b00);
    @(negedge clk); check_val("lu_stall", ctrl, LU_C);
    check_val("lu_cnt_before", bubble_cnt, 0);
    tick();
    @(negedge clk); check_val("lu_release", ctrl, IDLE_C);
    check_val("lu_cnt", bubble_cnt, 1);
    tick(); nop();
    @(negedge clk); check_val("lu_fwdA", forwardAE, 2'b01);
    check_val("lu_fwdB", forwardBE, 2'b00);

    // ALU back-to-back, two writers of x3 (M and W) -> M wins
    tick(); set_d(5'd1, 5'd2, 5'd3, 1'b1, 2'b00);
    tick(); set_d(5'd1, 5'd2, 5'd3, 1'b1, 2'b00);
    tick(); set_d(5'd3, 5'd3, 5'd4, 1'b1, 2'b00);
    @(negedge clk); check_val("alu_nostall", ctrl, IDLE_C);
    tick(); nop();
    @(negedge clk); check_val("alu_fwdA", forwardAE, 2'b10);
    check_val("alu_fwdB", forwardBE, 2'b10);

    // W-only forward: add x8 ; nop ; and x9,x8,x0
    tick(); set_d(5'd1, 5'd2, 5'd8, 1'b1, 2'b00);
    tick(); nop();
    tick(); set_d(5'd8, 5'd0, 5'd9, 1'b1, 2'b00);
    tick(); nop();
    @(negedge clk); check_val("w_fwdA", forwardAE, 2'b01);
    check_val("w_fwdB", forwardBE, 2'b00);

    // redirect + load-use in the same cycle -> redirect only
    tick(); set_d(5'd1, 5'd2, 5'd10, 1'b1, 2'b01);
    tick(); set_d(5'd10, 5'd0, 5'd11, 1'b1, 2'b00); pc_srcE = 1'b1;
    @(negedge clk); check_val("redir_lu_ctrl", ctrl, RED_C);
    check_val("redir_cnt_before", bubble_cnt, 1);
    tick(); pc_srcE = 1'b0; nop();
    @(negedge clk); check_val("post_redir_ctrl", ctrl, IDLE_C);
    check_val("redir_cnt", bubble_cnt, 3);

    // memory wait for 3 cycles, redirect pending from the second cycle on
    tick(); dmem_reqM = 1'b1; dmem_readyM = 1'b0;
    @(negedge clk); check_val("wait1_ctrl", ctrl, WAIT_C);
    tick(); pc_srcE = 1'b1;
    @(negedge clk); check_val("wait2_ctrl", ctrl, WAIT_C);
    check_val("wait2_cnt", bubble_cnt, 4);
    tick();
    @(negedge clk); check_val("wait3_ctrl", ctrl, WAIT_C);
    tick(); dmem_readyM = 1'b1;
    @(negedge clk); check_val("ready_redir_ctrl", ctrl, RED_C);
    check_val("wait_cnt", bubble_cnt, 6);
    tick(); dmem_reqM = 1'b0; dmem_readyM = 1'b0; pc_srcE = 1'b0;
    @(negedge clk); check_val("after_wait_ctrl", ctrl, IDLE_C);
    check_val("after_wait_cnt", bubble_cnt, 8);

    // ready in the same cycle as the request -> no wait
    tick(); dmem_reqM = 1'b1; dmem_readyM = 1'b1;
    @(negedge clk); check_val("ready_same_ctrl", ctrl, IDLE_C);
    tick(); dmem_reqM = 1'b0; dmem_readyM = 1'b0;
    @(negedge clk); check_val("still_run_ctrl", ctrl, IDLE_C);
    check_val("ready_same_cnt", bubble_cnt, 8);

    // E and M hold during a wait: add x20 stays in E, then forwards from M
    tick(); set_d(5'd1, 5'd2, 5'd20, 1'b1, 2'b00);
    tick(); set_d(5'd20, 5'd0, 5'd21, 1'b1, 2'b00); dmem_reqM = 1'b1;
    @(negedge clk); check_val("hold_wait_ctrl", ctrl, WAIT_C);
    tick(); dmem_readyM = 1'b1;
    @(negedge clk); check_val("hold_ready_ctrl", ctrl, IDLE_C);
    tick(); dmem_reqM = 1'b0; dmem_readyM = 1'b0; nop();
    @(negedge clk); check_val("hold_fwdA", forwardAE, 2'b10);
    check_val("hold_cnt", bubble_cnt, 9);

    // asynchronous reset in the middle of a wait
    tick(); dmem_reqM = 1'b1;
    tick();
    @(negedge clk); check_val("rst_pre_ctrl", ctrl, WAIT_C);
    #2 rst_n = 1'b0;
    #1 check_val("rst_async_ctrl", ctrl, BOOT_C);
    check_val("rst_async_cnt", bubble_cnt, 0);
    dmem_reqM = 1'b0;
    tick(); rst_n = 1'b1;
    @(negedge clk); check_val("rst_boot_ctrl", ctrl, BOOT_C);
    tick();
    @(negedge clk); check_val("rst_run_ctrl", ctrl, IDLE_C);
    check_val("rst_run_cnt", bubble_cnt, 0);

    // load to x0 then use of x0 -> no stall, no forward
    tick(); set_d(5'd0, 5'd0, 5'd0, 1'b1, 2'b01);
    tick(); set_d(5'd0, 5'd0, 5'd6, 1'b1, 2'b00);
    @(negedge clk); check_val("x0_nostall", ctrl, IDLE_C);
    tick(); nop();
    @(negedge clk); check_val("x0_fwdA", forwardAE, 2'b00);
    check_val("x0_cnt", bubble_cnt, 0);

    // saturation: +2 per redirect cycle from 0
    tick(); pc_srcE = 1'b1;
    repeat (32767) @(posedge clk);
    #1;
    @(negedge clk); check_val("sat_pre", bubble_cnt, 16'hFFFE);
    tick();
    @(negedge clk); check_val("sat_hit", bubble_cnt, 16'hFFFF);
    tick();
    @(negedge clk); check_val("sat_hold", bubble_cnt, 16'hFFFF);
    tick(); pc_srcE = 1'b0;

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage pipelined RISC-V core. It drives stall and flush enables for the F/D/E/M/W pipeline registers and computes operand forwarding selects for the execute stage. It keeps a shadow scoreboard of the destination register, write-enable and load flag for the E, M and W stages. It also sequences multi-cycle data-memory accesses through a small FSM.

Parameters:
REG_W, 5, register index width
CNT_W, 16, width of bubble performance counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
rs1D  in  REG_W  decode-stage source 1 index
rs2D  in  REG_W  decode-stage source 2 index
rdD  in  REG_W  decode-stage destination index
reg_writeD  in  1  decode-stage register write enable
result_srcD  in  2  decode result select; 2'b01 = load
pc_srcE  in  1  branch taken / jump / jalr redirect resolved in E
dmem_reqM  in  1  memory-stage access in flight
dmem_readyM  in  1  data memory completes access this cycle
stallF  out  1  hold PC register
stallD  out  1  hold F/D register
flushD  out  1  clear F/D register to bubble
stallE  out  1  hold D/E register
flushE  out  1  clear D/E register to bubble
stallM  out  1  hold E/M register
flushW  out  1  clear M/W register to bubble
forwardAE  out  2  operand A select: 00 reg file, 10 from M, 01 from W
forwardBE  out  2  operand B select, same encoding
bubble_cnt  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset is asynchronous on rst_n low.
  - Scoreboard entries E/M/W are invalid (rd=0, we=0, ld=0); rs1E/rs2E = 0; bubble_cnt = 0; state = BOOT.
  - Stall/flush/forward outputs are combinational from state and scoreboard.
  - In BOOT: flushD=flushE=1 and all stalls = 0.
- States:
  - BOOT -> RUN unconditionally after 1 cycle.
  - RUN -> MEM_WAIT when dmem_reqM & !dmem_readyM.
  - MEM_WAIT -> RUN when dmem_readyM.
  - Reset from any state -> BOOT. Reset mid-MEM_WAIT abandons the access; no stall is asserted afterwards.
- RUN, load-use hazard:
  - Condition: ldE & weE & rdE!=0 & (rdE==rs1D | rdE==rs2D).
  - Response: stallF=stallD=1, flushE=1, bubble_cnt += 1.
- RUN, redirect: pc_srcE=1 gives flushD=flushE=1, stallF=stallD=0, bubble_cnt += 2.
  - Redirect has priority over load-use. Simultaneous redirect + load-use gives the redirect response only.
- MEM_WAIT, and the RUN cycle in which the wait condition is first detected:
  - stallF=stallD=stallE=stallM=1, flushW=1, flushD=flushE=0.
  - pc_srcE and load-use are ignored while waiting because E is frozen; they are re-evaluated on the first RUN cycle.
  - bubble_cnt += 1 per waiting cycle.
  - If dmem_readyM arrives in the same cycle as dmem_reqM, no wait and no stall.
- Scoreboard advance, each cycle, in stage order.
  - No memory wait:
    - W <= M, M <= E.
    - E <= {rdD, reg_writeD, result_srcD==01} and rs1E/rs2E <= rs1D/rs2D.
    - If flushE, E <= invalid instead.
  - Memory wait: E and M hold, W <= invalid.
- Forwarding, combinational, for operand A (B identical with rs2E):
  - 10 if weM & rdM!=0 & rdM==rs1E.
  - else 01 if weW & rdW!=0 & rdW==rs1E.
  - else 00.
  - M has priority over W. x0 is never forwarded.
- bubble_cnt saturates at all-ones and never wraps.
- Latency: all control outputs are valid in the same cycle as their inputs (combinational from inputs and registered scoreboard). The scoreboard updates on the next rising edge.

Test Plan:
1. Reset: assert rst_n=0 mid-run -> all outputs clear immediately except the BOOT flushes; after release, 1 cycle flushD=flushE=1, then RUN with all controls 0 and bubble_cnt=0.
2. Load-use: lw x5 then add x6,x5,x7 -> one cycle of stallF=stallD=flushE=1; next cycle forwardAE=01 (x5 from W); bubble_cnt=1.
3. ALU back-to-back: add x3,.. then sub x4,x3,x3 -> forwardAE=forwardBE=10 and no stall. A second writer of x3 in W at the same time still selects 10.
4. Redirect with load-use: pc_srcE=1 while a load in E matches rs1D -> flushD=flushE=1, stallF=stallD=0, bubble_cnt += 2.
5. Memory wait: dmem_reqM=1 with dmem_readyM low for 3 cycles -> stallF/D/E/M=1 and flushW=1 for 3 cycles; on ready, back to RUN; bubble_cnt += 3. A pending pc_srcE is honoured only after ready.
6. x0 and saturation: a load to x0 followed by a use of x0 -> no stall and forward 00. Preload bubble_cnt near max and force extra bubbles -> the counter holds at all-ones.
